// File: rtl/paged_seg_display.sv
// Paged 7-segment display driver: a debounced button selects one of CHANNELS 16-bit values.
// The selected value is shown in decimal on digits 0..4, and the page index is shown in hex on the top digit.
module paged_seg_display #(
  parameter int DIGITS       = 8,
  parameter int CHANNELS     = 6,
  parameter int REFRESH_DIV  = 100000,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        BTNU,
  input  logic [16*CHANNELS-1:0]      vals,
  output logic [DIGITS-1:0]           AN,
  output logic [6:0]                  led,
  output logic [$clog2(CHANNELS)-1:0] page
);

  localparam int PW    = $clog2(CHANNELS);
  localparam int RW    = $clog2(REFRESH_DIV);
  localparam int DW    = $clog2(DEBOUNCE_CYC);
  localparam int IW    = $clog2(DIGITS);
  localparam int NSLOT = 1 << IW;

  typedef enum logic [1:0] {IDLE, SHIFT, LOAD} conv_state_t;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Button path
  logic          btn_meta_reg, btn_sync_reg, btn_last_reg;
  logic          btn_deb_reg, btn_deb_prev_reg, armed_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          stable;
  logic          adv;
  logic [PW-1:0] page_reg;

  assign stable = (deb_cnt_reg == DW'(DEBOUNCE_CYC - 1));
  // The debounced level has to be seen low at least once after reset before a rise counts.
  // As a result, a press that is held across reset is ignored.
  assign adv    = btn_deb_reg & ~btn_deb_prev_reg & armed_reg;
  assign page   = page_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_meta_reg     <= 1'b0;
      btn_sync_reg     <= 1'b0;
      btn_last_reg     <= 1'b0;
      btn_deb_reg      <= 1'b0;
      btn_deb_prev_reg <= 1'b0;
      armed_reg        <= 1'b0;
      deb_cnt_reg      <= '0;
      page_reg         <= '0;
    end else begin
      btn_meta_reg     <= BTNU;
      btn_sync_reg     <= btn_meta_reg;
      btn_last_reg     <= btn_sync_reg;
      btn_deb_prev_reg <= btn_deb_reg;
      if (btn_sync_reg != btn_last_reg)
        deb_cnt_reg <= '0;
      else if (!stable)
        deb_cnt_reg <= deb_cnt_reg + 1'b1;
      if (stable) begin
        btn_deb_reg <= btn_last_reg;
        if (!btn_last_reg)
          armed_reg <= 1'b1;
      end
      if (adv)
        page_reg <= (page_reg == PW'(CHANNELS - 1)) ? '0 : page_reg + 1'b1;
    end
  end

  // Binary-to-BCD converter
  logic [15:0]  chan [CHANNELS];
  conv_state_t  state_reg;
  logic [15:0]  shift_reg;
  logic [19:0]  bcd_reg;
  logic [19:0]  bcd_adj;
  logic [3:0]   step_reg;
  logic [19:0]  disp_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign chan[gi] = vals[16*gi +: 16];
  end

  for (genvar gi = 0; gi < 5; gi++) begin : g_adj
    assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                              : bcd_reg[4*gi +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      bcd_reg   <= '0;
      step_reg  <= '0;
      disp_reg  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          shift_reg <= chan[page_reg];
          bcd_reg   <= '0;
          step_reg  <= '0;
          state_reg <= SHIFT;
        end
        SHIFT: begin
          // A page change here leaves a stale half-converted value; drop it and restart.
          if (adv) begin
            state_reg <= IDLE;
          end else begin
            {bcd_reg, shift_reg} <= {bcd_adj, shift_reg} << 1;
            step_reg <= step_reg + 1'b1;
            if (step_reg == 4'd15)
              state_reg <= LOAD;
          end
        end
        LOAD: begin
          disp_reg  <= bcd_reg;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Digit multiplexing
  logic [RW-1:0] ref_cnt_reg;
  logic [IW-1:0] digit_idx_reg;
  logic [3:0]    slot_nib   [NSLOT];
  logic          slot_blank [NSLOT];
  logic [6:0]    seg_next;

  for (genvar gi = 0; gi < NSLOT; gi++) begin : g_slot
    if (gi == 0) begin : g_ones
      assign slot_nib[gi]   = disp_reg[3:0];
      assign slot_blank[gi] = 1'b0;
    end else if (gi < 5) begin : g_bcd
      assign slot_nib[gi]   = disp_reg[4*gi +: 4];
      assign slot_blank[gi] = (disp_reg[19:4*gi] == '0);
    end else begin : g_empty
      assign slot_nib[gi]   = 4'h0;
      assign slot_blank[gi] = 1'b1;
    end
  end

  always_comb begin
    seg_next = 7'h7F;
    if (digit_idx_reg == IW'(DIGITS - 1))
      seg_next = hex7(4'(page_reg));
    else if (!slot_blank[digit_idx_reg])
      seg_next = hex7(slot_nib[digit_idx_reg]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_reg   <= '0;
      digit_idx_reg <= '0;
      AN            <= '1;
      led           <= 7'h7F;
    end else begin
      AN  <= ~(DIGITS'(1) << digit_idx_reg);
      led <= seg_next;
      if (ref_cnt_reg == RW'(REFRESH_DIV - 1)) begin
        ref_cnt_reg   <= '0;
        digit_idx_reg <= (digit_idx_reg == IW'(DIGITS - 1)) ? '0 : digit_idx_reg + 1'b1;
      end else begin
        ref_cnt_reg <= ref_cnt_reg + 1'b1;
      end
    end
  end

endmodule
